avalon_csr_bank: RTL and testbench

Parametrised Avalon-MM slave register bank for the video IP control paths. It is the next generation of the image-store control slave and adds the following:
- per-register access modes: read-write, read-only status, and write-1-to-clear event registers;
- byte enables and a configurable fixed read latency with `av_readdatavalid`;
- per-register write strobes;
- an optional masked interrupt.

It sits between the system interconnect and a video core's datapath.

---
 rtl/avalon_csr_bank.sv | 142 ++++++++++++++
 tb/tb_avalon_csr_bank.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/avalon_csr_bank.sv
// Avalon-MM register bank with read-write, read-only and W1C registers, byte enables and fixed read latency.
// Define CSR_BANK_IRQ_EN to add the IRQ mask register at address REGS_NUM and drive a masked interrupt.
module avalon_csr_bank #(
  parameter int                              ADDR_WIDTH   = 4,
  parameter int                              DATA_WIDTH   = 32,
  parameter int                              REGS_NUM     = 10,
  parameter logic [REGS_NUM-1:0]             REGS_RO      = '0,
  parameter logic [REGS_NUM-1:0]             REGS_W1C     = '0,
  parameter logic [REGS_NUM*DATA_WIDTH-1:0]  REGS_INIT    = '0,
  parameter int                              READ_LATENCY = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [ADDR_WIDTH-1:0]          av_address,
  input  logic                           av_read,
  input  logic                           av_write,
  input  logic [DATA_WIDTH/8-1:0]        av_byteenable,
  input  logic [DATA_WIDTH-1:0]          av_writedata,
  output logic [DATA_WIDTH-1:0]          av_readdata,
  output logic                           av_readdatavalid,
  input  logic [REGS_NUM*DATA_WIDTH-1:0] reg_in,
  input  logic [REGS_NUM*DATA_WIDTH-1:0] ev_in,
  output logic [REGS_NUM*DATA_WIDTH-1:0] reg_out,
  output logic [REGS_NUM-1:0]            reg_wr_strobe,
  output logic                           irq
);
  localparam int BYTES = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] be_mask;
  logic [DATA_WIDTH-1:0] wr_bits;
  logic [DATA_WIDTH-1:0] stored [REGS_NUM];
  logic [DATA_WIDTH-1:0] rd_val [REGS_NUM];
  logic [REGS_NUM-1:0]   strobe_d;
  logic [REGS_NUM-1:0]   strobe_q;
  logic [REGS_NUM-1:0]   w1c_any;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  s1_valid;
  logic [DATA_WIDTH-1:0] s1_data;
  logic                  unused_bits;

  always_comb begin
    be_mask = '0;
    for (int b = 0; b < BYTES; b++) be_mask[8*b +: 8] = {8{av_byteenable[b]}};
  end
  assign wr_bits = av_writedata & be_mask;

  for (genvar i = 0; i < REGS_NUM; i++) begin : g_reg
    localparam logic IS_RO  = REGS_RO[i];
    localparam logic IS_W1C = REGS_W1C[i] && !REGS_RO[i];
    logic hit;
    assign hit = av_write && (av_address == ADDR_WIDTH'(i));
    if (IS_RO) begin : g_ro
      assign stored[i]   = '0;
      assign rd_val[i]   = reg_in[DATA_WIDTH*i +: DATA_WIDTH];
      assign strobe_d[i] = 1'b0;
    end else begin : g_rw
      logic [DATA_WIDTH-1:0] q_r;
      // For W1C, the event OR is applied after the clear so a simultaneous set wins.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          q_r <= IS_W1C ? '0 : REGS_INIT[DATA_WIDTH*i +: DATA_WIDTH];
        end else if (IS_W1C) begin
          q_r <= (q_r & ~(hit ? wr_bits : '0)) | ev_in[DATA_WIDTH*i +: DATA_WIDTH];
        end else if (hit) begin
          q_r <= (q_r & ~be_mask) | wr_bits;
        end
      end
      assign stored[i]   = q_r;
      assign rd_val[i]   = q_r;
      assign strobe_d[i] = hit;
    end
    assign w1c_any[i] = IS_W1C && (|stored[i]);
    assign reg_out[DATA_WIDTH*i +: DATA_WIDTH] = stored[i];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) strobe_q <= '0;
    else        strobe_q <= strobe_d;
  end
  assign reg_wr_strobe = strobe_q;

`ifdef CSR_BANK_IRQ_EN
  logic [DATA_WIDTH-1:0] mask_q;
  logic                  mask_hit;
  logic                  irq_q;
  assign mask_hit = av_write && (av_address == ADDR_WIDTH'(REGS_NUM));
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mask_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      if (mask_hit) mask_q <= (mask_q & ~be_mask) | wr_bits;
      irq_q <= |(mask_q[REGS_NUM-1:0] & w1c_any);
    end
  end
  assign irq = irq_q;
  assign unused_bits = ^{reg_in, ev_in, mask_q};
`else
  assign irq = 1'b0;
  assign unused_bits = ^{reg_in, ev_in, w1c_any};
`endif

  // Unmatched addresses fall through to zero.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < REGS_NUM; i++) begin
      if (av_address == ADDR_WIDTH'(i)) rd_data = rd_val[i];
    end
`ifdef CSR_BANK_IRQ_EN
    if (av_address == ADDR_WIDTH'(REGS_NUM)) rd_data = mask_q;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else begin
      s1_valid <= av_read;
      s1_data  <= av_read ? rd_data : '0;
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic                  s2_valid;
    logic [DATA_WIDTH-1:0] s2_data;
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        s2_valid <= 1'b0;
        s2_data  <= '0;
      end else begin
        s2_valid <= s1_valid;
        s2_data  <= s1_data;
      end
    end
    assign av_readdatavalid = s2_valid;
    assign av_readdata      = s2_data;
  end else begin : g_lat1
    assign av_readdatavalid = s1_valid;
    assign av_readdata      = s1_data;
  end
endmodule

// File: tb/tb_avalon_csr_bank.sv
// Directed bench: two instances (read latency 1 and 2) share one stimulus stream.
module tb_avalon_csr_bank;
  localparam int AW = 4;
  localparam int DW = 32;
  localparam int RN = 4;
  localparam logic [RN*DW-1:0] INIT = {32'h0, 32'h0, 32'h0, 32'h1234_5678};

  logic            clk;
  logic            rst_n;
  logic [AW-1:0]   av_address;
  logic            av_read;
  logic            av_write;
  logic [DW/8-1:0] av_byteenable;
  logic [DW-1:0]   av_writedata;
  logic [RN*DW-1:0] reg_in;
  logic [RN*DW-1:0] ev_in;

  logic [DW-1:0]    l1_data, l2_data;
  logic             l1_valid, l2_valid;
  logic [RN*DW-1:0] l1_reg_out, l2_reg_out;
  logic [RN-1:0]    l1_strobe, l2_strobe;
  logic             l1_irq, l2_irq;

  int tests = 0;
  int fails = 0;

  avalon_csr_bank #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .REGS_NUM(RN),
    .REGS_RO(4'b0010), .REGS_W1C(4'b0100), .REGS_INIT(INIT), .READ_LATENCY(1)
  ) dut_l1 (
    .clk(clk), .rst_n(rst_n), .av_address(av_address), .av_read(av_read),
    .av_write(av_write), .av_byteenable(av_byteenable), .av_writedata(av_writedata),
    .av_readdata(l1_data), .av_readdatavalid(l1_valid), .reg_in(reg_in), .ev_in(ev_in),
    .reg_out(l1_reg_out), .reg_wr_strobe(l1_strobe), .irq(l1_irq)
  );

  avalon_csr_bank #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .REGS_NUM(RN),
    .REGS_RO(4'b0010), .REGS_W1C(4'b0100), .REGS_INIT(INIT), .READ_LATENCY(2)
  ) dut_l2 (
    .clk(clk), .rst_n(rst_n), .av_address(av_address), .av_read(av_read),
    .av_write(av_write), .av_byteenable(av_byteenable), .av_writedata(av_writedata),
    .av_readdata(l2_data), .av_readdatavalid(l2_valid), .reg_in(reg_in), .ev_in(ev_in),
    .reg_out(l2_reg_out), .reg_wr_strobe(l2_strobe), .irq(l2_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 ns after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [AW-1:0] a);
    av_read = 1'b1; av_address = a;
    tick();
    av_read = 1'b0;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] be);
    av_write = 1'b1; av_address = a; av_writedata = d; av_byteenable = be;
    tick();
    av_write = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    tests++; if (l1_valid !== 1'b0 || l1_data !== 32'h0) begin fails++; $display("FAIL reset_rd: valid=%b data=%h want 0/0", l1_valid, l1_data); end
    tests++; if (l2_valid !== 1'b0 || l2_data !== 32'h0) begin fails++; $display("FAIL reset_rd_l2: valid=%b data=%h want 0/0", l2_valid, l2_data); end
    tests++; if (l1_strobe !== 4'b0 || l1_irq !== 1'b0) begin fails++; $display("FAIL reset_strobe_irq: strobe=%b irq=%b want 0000/0", l1_strobe, l1_irq); end
    tests++; if (l1_reg_out !== INIT) begin fails++; $display("FAIL reset_regs: got %h want %h", l1_reg_out, INIT); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_rw();
    rd(4'd0);
    tests++; if (l1_valid !== 1'b1 || l1_data !== 32'h1234_5678) begin fails++; $display("FAIL rw_read_init: valid=%b data=%h want 1/12345678", l1_valid, l1_data); end
    tick();
    tests++; if (l1_valid !== 1'b0) begin fails++; $display("FAIL rw_valid_once: valid=%b want 0", l1_valid); end
    wr(4'd0, 32'hAABB_CCDD, 4'b0101);
    tests++; if (l1_reg_out[31:0] !== 32'h12BB_56DD || l1_strobe !== 4'b0001) begin fails++; $display("FAIL rw_be_write: reg0=%h strobe=%b want 12bb56dd/0001", l1_reg_out[31:0], l1_strobe); end
    tick();
    tests++; if (l1_strobe !== 4'b0000) begin fails++; $display("FAIL rw_strobe_pulse: strobe=%b want 0000", l1_strobe); end
    wr(4'd3, 32'hFFFF_FFFF, 4'b0000);
    tests++; if (l1_strobe !== 4'b1000 || l1_reg_out[127:96] !== 32'h0) begin fails++; $display("FAIL rw_be_zero: strobe=%b reg3=%h want 1000/0", l1_strobe, l1_reg_out[127:96]); end
    rd(4'd0);
    tests++; if (l1_valid !== 1'b1 || l1_data !== 32'h12BB_56DD) begin fails++; $display("FAIL rw_readback: valid=%b data=%h want 1/12bb56dd", l1_valid, l1_data); end
    tick();
  endtask

  task automatic test_ro();
    rd(4'd1);
    tests++; if (l1_valid !== 1'b1 || l1_data !== 32'hCAFE_0001) begin fails++; $display("FAIL ro_read: valid=%b data=%h want 1/cafe0001", l1_valid, l1_data); end
    wr(4'd1, 32'hFFFF_FFFF, 4'b1111);
    tests++; if (l1_strobe !== 4'b0000 || l1_reg_out[63:32] !== 32'h0) begin fails++; $display("FAIL ro_write_ignored: strobe=%b reg1=%h want 0000/0", l1_strobe, l1_reg_out[63:32]); end
    rd(4'd1);
    tests++; if (l1_data !== 32'hCAFE_0001) begin fails++; $display("FAIL ro_reread: data=%h want cafe0001", l1_data); end
    tick();
  endtask

  task automatic test_w1c();
    ev_in[67] = 1'b1;
    tick();
    ev_in = '0;
    tests++; if (l1_reg_out[95:64] !== 32'h8) begin fails++; $display("FAIL w1c_event: reg2=%h want 8", l1_reg_out[95:64]); end
    rd(4'd2);
    tests++; if (l1_valid !== 1'b1 || l1_data !== 32'h8) begin fails++; $display("FAIL w1c_read: valid=%b data=%h want 1/8", l1_valid, l1_data); end
    ev_in[67] = 1'b1;
    wr(4'd2, 32'h8, 4'b1111);
    ev_in = '0;
    tests++; if (l1_reg_out[95:64] !== 32'h8 || l1_strobe !== 4'b0100) begin fails++; $display("FAIL w1c_set_wins: reg2=%h strobe=%b want 8/0100", l1_reg_out[95:64], l1_strobe); end
    wr(4'd2, 32'h8, 4'b1111);
    tests++; if (l1_reg_out[95:64] !== 32'h0) begin fails++; $display("FAIL w1c_clear: reg2=%h want 0", l1_reg_out[95:64]); end
    tick();
  endtask

  task automatic test_out_of_range();
    rd(4'd7);
    tests++; if (l1_valid !== 1'b1 || l1_data !== 32'h0) begin fails++; $display("FAIL oor_read: valid=%b data=%h want 1/0", l1_valid, l1_data); end
    wr(4'd7, 32'hFFFF_FFFF, 4'b1111);
    tests++; if (l1_strobe !== 4'b0000 || l1_reg_out[31:0] !== 32'h12BB_56DD) begin fails++; $display("FAIL oor_write: strobe=%b reg0=%h want 0000/12bb56dd", l1_strobe, l1_reg_out[31:0]); end
    tick();
  endtask

  task automatic test_back_to_back();
    av_read = 1'b1; av_address = 4'd0;
    tick();
    tests++; if (l2_valid !== 1'b0 || l1_data !== 32'h12BB_56DD) begin fails++; $display("FAIL b2b_c0: l2_valid=%b l1_data=%h want 0/12bb56dd", l2_valid, l1_data); end
    av_address = 4'd1;
    tick();
    tests++; if (l2_valid !== 1'b1 || l2_data !== 32'h12BB_56DD) begin fails++; $display("FAIL b2b_c1: valid=%b data=%h want 1/12bb56dd", l2_valid, l2_data); end
    av_address = 4'd7;
    tick();
    tests++; if (l2_valid !== 1'b1 || l2_data !== 32'hCAFE_0001) begin fails++; $display("FAIL b2b_c2: valid=%b data=%h want 1/cafe0001", l2_valid, l2_data); end
    av_read = 1'b0;
    tick();
    tests++; if (l2_valid !== 1'b1 || l2_data !== 32'h0 || l1_valid !== 1'b0) begin fails++; $display("FAIL b2b_c3: valid=%b data=%h l1_valid=%b want 1/0/0", l2_valid, l2_data, l1_valid); end
    tick();
    tests++; if (l2_valid !== 1'b0) begin fails++; $display("FAIL b2b_end: valid=%b want 0", l2_valid); end
  endtask

  task automatic test_reset_midstream();
    av_read = 1'b1; av_address = 4'd0;
    tick();
    rst_n = 1'b0;
    tick();
    tests++; if (l2_valid !== 1'b0 || l1_valid !== 1'b0) begin fails++; $display("FAIL flush_c1: l2_valid=%b l1_valid=%b want 0/0", l2_valid, l1_valid); end
    av_read = 1'b0;
    tick();
    tests++; if (l2_valid !== 1'b0 || l2_reg_out[31:0] !== 32'h1234_5678) begin fails++; $display("FAIL flush_c2: valid=%b reg0=%h want 0/12345678", l2_valid, l2_reg_out[31:0]); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_irq();
`ifdef CSR_BANK_IRQ_EN
    wr(4'd4, 32'h4, 4'b1111);
    tests++; if (l1_strobe !== 4'b0000) begin fails++; $display("FAIL irq_mask_strobe: strobe=%b want 0000", l1_strobe); end
    rd(4'd4);
    tests++; if (l1_data !== 32'h4) begin fails++; $display("FAIL irq_mask_read: data=%h want 4", l1_data); end
    ev_in[64] = 1'b1;
    tick();
    ev_in = '0;
    tests++; if (l1_irq !== 1'b0) begin fails++; $display("FAIL irq_lag: irq=%b want 0", l1_irq); end
    tick();
    tests++; if (l1_irq !== 1'b1) begin fails++; $display("FAIL irq_set: irq=%b want 1", l1_irq); end
    wr(4'd2, 32'h1, 4'b1111);
    tick();
    tests++; if (l1_irq !== 1'b0) begin fails++; $display("FAIL irq_clear: irq=%b want 0", l1_irq); end
    wr(4'd4, 32'h0, 4'b1111);
`else
    rd(4'd4);
    tests++; if (l1_valid !== 1'b1 || l1_data !== 32'h0) begin fails++; $display("FAIL noirq_addr4: valid=%b data=%h want 1/0", l1_valid, l1_data); end
`endif
    ev_in[64] = 1'b1;
    tick();
    ev_in = '0;
    tick();
    tests++; if (l1_irq !== 1'b0 || l1_reg_out[95:64] !== 32'h1) begin fails++; $display("FAIL irq_masked: irq=%b reg2=%h want 0/1", l1_irq, l1_reg_out[95:64]); end
    tick();
    tests++; if (l1_irq !== 1'b0) begin fails++; $display("FAIL irq_masked_hold: irq=%b want 0", l1_irq); end
    wr(4'd2, 32'h1, 4'b0001);
    tick();
  endtask

  initial begin
    rst_n = 1'b0; av_address = '0; av_read = 1'b0; av_write = 1'b0;
    av_byteenable = '0; av_writedata = '0; ev_in = '0;
    reg_in = '0;
    reg_in[63:32] = 32'hCAFE_0001;
    test_reset();
    test_rw();
    test_ro();
    test_w1c();
    test_out_of_range();
    test_back_to_back();
    test_reset_midstream();
    test_irq();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
